inv_sub_bytes_engine: RTL and testbench
=======================================

Name: inv_sub_bytes_engine

Overview:
- Sequential AES InvSubBytes unit for the decryption datapath; the inverse of the forward Rijndael S-box substitution used on the encrypt side.
- Accepts one 128-bit AES state over a valid/ready handshake.
- Applies the inverse S-box to BYTES_PER_CYCLE bytes per clock through internal inverse-S-box lookup instances.
- Returns the substituted 128-bit state over a second valid/ready handshake.

Parameters:
- BYTES_PER_CYCLE, 4: bytes substituted per BUSY cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error. Defines G = 16/BYTES_PER_CYCLE groups.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  engine can accept a state.
- in_state  input  128  ciphertext-side state. Byte 0 = [127:120], byte 15 = [7:0].
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  consumer accepts out_state.
- out_state  output  128  InvSubBytes(in_state), same byte ordering as in_state.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Internal registers: 128-bit work register and a group counter cnt (width clog2(G), minimum 1 bit).
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE; cnt=0; work register=0.
  - Outputs: in_ready=1, out_valid=0, busy=0, out_state=0.
  - Reset asserted mid-operation discards the state in flight; no partial result is ever presented.
- in_ready = (FSM==IDLE). out_valid = (FSM==DONE). out_state = work register at all times. busy = (FSM!=IDLE).
- IDLE:
  - On in_valid & in_ready, latch in_state into the work register, set cnt=0, go to BUSY.
  - With in_valid low, hold.
- BUSY:
  - Each edge replaces group cnt with its inverse S-box values. Group cnt covers bytes cnt*BYTES_PER_CYCLE through cnt*BYTES_PER_CYCLE+BYTES_PER_CYCLE-1.
  - Then cnt increments.
  - On the edge processing group G-1, cnt wraps to 0 and the FSM goes to DONE.
  - Bytes outside the current group are unchanged.
  - in_valid is ignored; in_ready is 0.
- DONE:
  - Hold the work register and out_valid=1 until out_valid & out_ready, then go to IDLE.
  - out_state must remain stable while out_valid=1 and out_ready=0.
- Latency: the acceptance edge, then G BUSY edges, then out_valid=1 (G=4 at the default).
- Minimum turnaround: acceptance to next acceptance is G+2 edges when out_ready is held high.
- Back-to-back input is not accepted in DONE. A new input is taken only from IDLE, the cycle after the output handshake.
- Inverse S-box: the exact inverse of the FIPS-197 forward S-box; a full 256-entry combinational case table, with the default arm returning 8'h00. Spot values:
  - 63→00, 7c→01, 77→02, 16→ff
  - 00→52, ed→53, 09→40, d4→19
- in_state changing while not being accepted has no effect.
- out_ready asserted outside DONE has no effect.

Test Plan:
1. Reset then idle: hold rst_n=0 for 3 cycles and release. Required: in_ready=1, out_valid=0, busy=0, out_state=0. With no stimulus for 10 cycles, nothing changes.
2. Single block, default parameter: in_state=637c777bf26b6fc53001672bfed7ab76, out_ready=1. Required: out_valid rises exactly 4 edges after acceptance, out_state=000102030405060708090a0b0c0d0e0f, and FSM returns to IDLE one edge later.
3. Backpressure and busy stall:
   - in_state=16161616…16 (all bytes 16). Drive in_valid continuously with a second value 63636363…63 and hold out_ready=0.
   - Required: in_ready stays 0 in BUSY and DONE, and out_state holds ffff…ff stable for 20 cycles.
   - Release out_ready; the second state is accepted from IDLE and yields all 00.
4. Reset mid-operation: accept 00000000…00, then drop rst_n asynchronously two edges later. Required: outputs reach reset values immediately with no out_valid pulse. After release, a new block ed ed … ed yields 53 53 … 53.
5. Parameter sweep over BYTES_PER_CYCLE ∈ {1, 2, 8, 16} on the stimulus of scenario 2: same result, out_valid after 16, 8, 2 and 1 edges respectively.
6. Exhaustive table check with BYTES_PER_CYCLE=16: feed all 256 byte values across 16 blocks. Required: forward-S-box(out byte) equals in byte for every entry.

Source files
------------

// File: rtl/inv_sub_bytes_engine.sv
// AES InvSubBytes engine: accepts one 128-bit state, substitutes BYTES_PER_CYCLE
// bytes per clock through inverse S-box lookups, and holds the result until it is taken.
module inv_sub_bytes_engine #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int G  = 16 / BYTES_PER_CYCLE;
  localparam int W  = 8 * BYTES_PER_CYCLE;
  localparam int CW = (G > 1) ? $clog2(G) : 1;

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
      $error("inv_sub_bytes_engine: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [127:0]    work;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    grp_in, grp_out;
  logic            last_grp;

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] s;
    case (b)
      8'h00: s = 8'h52; 8'h01: s = 8'h09; 8'h02: s = 8'h6a; 8'h03: s = 8'hd5; 8'h04: s = 8'h30; 8'h05: s = 8'h36; 8'h06: s = 8'ha5; 8'h07: s = 8'h38;
      8'h08: s = 8'hbf; 8'h09: s = 8'h40; 8'h0a: s = 8'ha3; 8'h0b: s = 8'h9e; 8'h0c: s = 8'h81; 8'h0d: s = 8'hf3; 8'h0e: s = 8'hd7; 8'h0f: s = 8'hfb;
      8'h10: s = 8'h7c; 8'h11: s = 8'he3; 8'h12: s = 8'h39; 8'h13: s = 8'h82; 8'h14: s = 8'h9b; 8'h15: s = 8'h2f; 8'h16: s = 8'hff; 8'h17: s = 8'h87;
      8'h18: s = 8'h34; 8'h19: s = 8'h8e; 8'h1a: s = 8'h43; 8'h1b: s = 8'h44; 8'h1c: s = 8'hc4; 8'h1d: s = 8'hde; 8'h1e: s = 8'he9; 8'h1f: s = 8'hcb;
      8'h20: s = 8'h54; 8'h21: s = 8'h7b; 8'h22: s = 8'h94; 8'h23: s = 8'h32; 8'h24: s = 8'ha6; 8'h25: s = 8'hc2; 8'h26: s = 8'h23; 8'h27: s = 8'h3d;
      8'h28: s = 8'hee; 8'h29: s = 8'h4c; 8'h2a: s = 8'h95; 8'h2b: s = 8'h0b; 8'h2c: s = 8'h42; 8'h2d: s = 8'hfa; 8'h2e: s = 8'hc3; 8'h2f: s = 8'h4e;
      8'h30: s = 8'h08; 8'h31: s = 8'h2e; 8'h32: s = 8'ha1; 8'h33: s = 8'h66; 8'h34: s = 8'h28; 8'h35: s = 8'hd9; 8'h36: s = 8'h24; 8'h37: s = 8'hb2;
      8'h38: s = 8'h76; 8'h39: s = 8'h5b; 8'h3a: s = 8'ha2; 8'h3b: s = 8'h49; 8'h3c: s = 8'h6d; 8'h3d: s = 8'h8b; 8'h3e: s = 8'hd1; 8'h3f: s = 8'h25;
      8'h40: s = 8'h72; 8'h41: s = 8'hf8; 8'h42: s = 8'hf6; 8'h43: s = 8'h64; 8'h44: s = 8'h86; 8'h45: s = 8'h68; 8'h46: s = 8'h98; 8'h47: s = 8'h16;
      8'h48: s = 8'hd4; 8'h49: s = 8'ha4; 8'h4a: s = 8'h5c; 8'h4b: s = 8'hcc; 8'h4c: s = 8'h5d; 8'h4d: s = 8'h65; 8'h4e: s = 8'hb6; 8'h4f: s = 8'h92;
      8'h50: s = 8'h6c; 8'h51: s = 8'h70; 8'h52: s = 8'h48; 8'h53: s = 8'h50; 8'h54: s = 8'hfd; 8'h55: s = 8'hed; 8'h56: s = 8'hb9; 8'h57: s = 8'hda;
      8'h58: s = 8'h5e; 8'h59: s = 8'h15; 8'h5a: s = 8'h46; 8'h5b: s = 8'h57; 8'h5c: s = 8'ha7; 8'h5d: s = 8'h8d; 8'h5e: s = 8'h9d; 8'h5f: s = 8'h84;
      8'h60: s = 8'h90; 8'h61: s = 8'hd8; 8'h62: s = 8'hab; 8'h63: s = 8'h00; 8'h64: s = 8'h8c; 8'h65: s = 8'hbc; 8'h66: s = 8'hd3; 8'h67: s = 8'h0a;
      8'h68: s = 8'hf7; 8'h69: s = 8'he4; 8'h6a: s = 8'h58; 8'h6b: s = 8'h05; 8'h6c: s = 8'hb8; 8'h6d: s = 8'hb3; 8'h6e: s = 8'h45; 8'h6f: s = 8'h06;
      8'h70: s = 8'hd0; 8'h71: s = 8'h2c; 8'h72: s = 8'h1e; 8'h73: s = 8'h8f; 8'h74: s = 8'hca; 8'h75: s = 8'h3f; 8'h76: s = 8'h0f; 8'h77: s = 8'h02;
      8'h78: s = 8'hc1; 8'h79: s = 8'haf; 8'h7a: s = 8'hbd; 8'h7b: s = 8'h03; 8'h7c: s = 8'h01; 8'h7d: s = 8'h13; 8'h7e: s = 8'h8a; 8'h7f: s = 8'h6b;
      8'h80: s = 8'h3a; 8'h81: s = 8'h91; 8'h82: s = 8'h11; 8'h83: s = 8'h41; 8'h84: s = 8'h4f; 8'h85: s = 8'h67; 8'h86: s = 8'hdc; 8'h87: s = 8'hea;
      8'h88: s = 8'h97; 8'h89: s = 8'hf2; 8'h8a: s = 8'hcf; 8'h8b: s = 8'hce; 8'h8c: s = 8'hf0; 8'h8d: s = 8'hb4; 8'h8e: s = 8'he6; 8'h8f: s = 8'h73;
      8'h90: s = 8'h96; 8'h91: s = 8'hac; 8'h92: s = 8'h74; 8'h93: s = 8'h22; 8'h94: s = 8'he7; 8'h95: s = 8'had; 8'h96: s = 8'h35; 8'h97: s = 8'h85;
      8'h98: s = 8'he2; 8'h99: s = 8'hf9; 8'h9a: s = 8'h37; 8'h9b: s = 8'he8; 8'h9c: s = 8'h1c; 8'h9d: s = 8'h75; 8'h9e: s = 8'hdf; 8'h9f: s = 8'h6e;
      8'ha0: s = 8'h47; 8'ha1: s = 8'hf1; 8'ha2: s = 8'h1a; 8'ha3: s = 8'h71; 8'ha4: s = 8'h1d; 8'ha5: s = 8'h29; 8'ha6: s = 8'hc5; 8'ha7: s = 8'h89;
      8'ha8: s = 8'h6f; 8'ha9: s = 8'hb7; 8'haa: s = 8'h62; 8'hab: s = 8'h0e; 8'hac: s = 8'haa; 8'had: s = 8'h18; 8'hae: s = 8'hbe; 8'haf: s = 8'h1b;
      8'hb0: s = 8'hfc; 8'hb1: s = 8'h56; 8'hb2: s = 8'h3e; 8'hb3: s = 8'h4b; 8'hb4: s = 8'hc6; 8'hb5: s = 8'hd2; 8'hb6: s = 8'h79; 8'hb7: s = 8'h20;
      8'hb8: s = 8'h9a; 8'hb9: s = 8'hdb; 8'hba: s = 8'hc0; 8'hbb: s = 8'hfe; 8'hbc: s = 8'h78; 8'hbd: s = 8'hcd; 8'hbe: s = 8'h5a; 8'hbf: s = 8'hf4;
      8'hc0: s = 8'h1f; 8'hc1: s = 8'hdd; 8'hc2: s = 8'ha8; 8'hc3: s = 8'h33; 8'hc4: s = 8'h88; 8'hc5: s = 8'h07; 8'hc6: s = 8'hc7; 8'hc7: s = 8'h31;
      8'hc8: s = 8'hb1; 8'hc9: s = 8'h12; 8'hca: s = 8'h10; 8'hcb: s = 8'h59; 8'hcc: s = 8'h27; 8'hcd: s = 8'h80; 8'hce: s = 8'hec; 8'hcf: s = 8'h5f;
      8'hd0: s = 8'h60; 8'hd1: s = 8'h51; 8'hd2: s = 8'h7f; 8'hd3: s = 8'ha9; 8'hd4: s = 8'h19; 8'hd5: s = 8'hb5; 8'hd6: s = 8'h4a; 8'hd7: s = 8'h0d;
      8'hd8: s = 8'h2d; 8'hd9: s = 8'he5; 8'hda: s = 8'h7a; 8'hdb: s = 8'h9f; 8'hdc: s = 8'h93; 8'hdd: s = 8'hc9; 8'hde: s = 8'h9c; 8'hdf: s = 8'hef;
      8'he0: s = 8'ha0; 8'he1: s = 8'he0; 8'he2: s = 8'h3b; 8'he3: s = 8'h4d; 8'he4: s = 8'hae; 8'he5: s = 8'h2a; 8'he6: s = 8'hf5; 8'he7: s = 8'hb0;
      8'he8: s = 8'hc8; 8'he9: s = 8'heb; 8'hea: s = 8'hbb; 8'heb: s = 8'h3c; 8'hec: s = 8'h83; 8'hed: s = 8'h53; 8'hee: s = 8'h99; 8'hef: s = 8'h61;
      8'hf0: s = 8'h17; 8'hf1: s = 8'h2b; 8'hf2: s = 8'h04; 8'hf3: s = 8'h7e; 8'hf4: s = 8'hba; 8'hf5: s = 8'h77; 8'hf6: s = 8'hd6; 8'hf7: s = 8'h26;
      8'hf8: s = 8'he1; 8'hf9: s = 8'h69; 8'hfa: s = 8'h14; 8'hfb: s = 8'h63; 8'hfc: s = 8'h55; 8'hfd: s = 8'h21; 8'hfe: s = 8'h0c; 8'hff: s = 8'h7d;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Byte 0 sits at the MSB, so group cnt starts cnt*W bits below bit 127.
  assign grp_in   = work[127 - W*int'(cnt) -: W];
  assign last_grp = (cnt == CW'(G - 1));

  generate
    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lut
      assign grp_out[W-1-8*j -: 8] = inv_sbox(grp_in[W-1-8*j -: 8]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = BUSY;
      BUSY:    if (last_grp)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The work register doubles as the output holding register once DONE is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work <= in_state;
            cnt  <= '0;
          end
        end
        BUSY: begin
          work[127 - W*int'(cnt) -: W] <= grp_out;
          cnt <= last_grp ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = work;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Self-checking bench: five engines (1..16 bytes/cycle) share stimulus and are
// compared every cycle against a GF(2^8)-derived InvSubBytes reference.
module tb_inv_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
  logic [4:0]   in_ready_v, out_valid_v, busy_v;
  logic [127:0] out_state_v [5];

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  logic [7:0]   fwd_tab [256];
  logic [7:0]   inv_tab [256];
  int           m_phase [5] = '{default: -1};
  logic [127:0] m_src   [5];
  logic [127:0] m_held  [5] = '{default: '0};
  int           lat     [5];

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] r;
    logic [7:0] s;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    s = inv;
    r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [127:0] partial_sub(input logic [127:0] v, input int nb);
    logic [127:0] r = v;
    for (int i = 0; i < nb; i++) r[127-8*i -: 8] = inv_tab[v[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] exp_out(input int k);
    if (m_phase[k] < 0) return m_held[k];
    return partial_sub(m_src[k], m_phase[k] * (1 << k));
  endfunction

  generate
    for (genvar k = 0; k < 5; k++) begin : g_dut
      localparam int G = 16 >> k;

      inv_sub_bytes_engine #(.BYTES_PER_CYCLE(1 << k)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready_v[k]),
        .in_state  (in_state),
        .out_valid (out_valid_v[k]),
        .out_ready (out_ready),
        .out_state (out_state_v[k]),
        .busy      (busy_v[k])
      );

      // Reference: phase counts edges since acceptance, -1 while idle.
      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          m_phase[k] <= -1;
          m_held[k]  <= '0;
        end else if (m_phase[k] < 0) begin
          if (in_valid) begin
            m_phase[k] <= 0;
            m_src[k]   <= in_state;
          end
        end else if (m_phase[k] < G) begin
          m_phase[k] <= m_phase[k] + 1;
        end else if (out_ready) begin
          m_phase[k] <= -1;
          m_held[k]  <= partial_sub(m_src[k], 16);
        end
      end
    end
  endgenerate

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 5; k++) begin
        checkOutput($sformatf("in_ready bpc=%0d", 1 << k), 128'(in_ready_v[k]), 128'(m_phase[k] < 0));
        checkOutput($sformatf("busy bpc=%0d", 1 << k), 128'(busy_v[k]), 128'(m_phase[k] >= 0));
        checkOutput($sformatf("out_valid bpc=%0d", 1 << k), 128'(out_valid_v[k]), 128'(m_phase[k] == (16 >> k)));
        checkOutput($sformatf("out_state bpc=%0d", 1 << k), out_state_v[k], exp_out(k));
      end
    end
  end

  // Drive one block for exactly one edge; called and returns at posedge+1.
  task automatic applyStimulus(input logic [127:0] v, input logic rdy);
    in_valid  = 1'b1;
    in_state  = v;
    out_ready = rdy;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] v;
    for (int i = 0; i < 256; i++) begin
      fwd_tab[i] = fwd_sbox(8'(i));
      inv_tab[fwd_tab[i]] = 8'(i);
    end
    checkOutput("model inv 63", 128'(inv_tab[8'h63]), 128'h00);
    checkOutput("model inv 7c", 128'(inv_tab[8'h7c]), 128'h01);
    checkOutput("model inv 16", 128'(inv_tab[8'h16]), 128'hff);
    checkOutput("model inv 00", 128'(inv_tab[8'h00]), 128'h52);
    checkOutput("model inv ed", 128'(inv_tab[8'hed]), 128'h53);
    checkOutput("model inv d4", 128'(inv_tab[8'hd4]), 128'h19);

    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    check_en  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset in_ready", 128'(in_ready_v[2]), 128'h1);
    checkOutput("reset out_valid", 128'(out_valid_v[2]), 128'h0);
    checkOutput("reset busy", 128'(busy_v[2]), 128'h0);
    checkOutput("reset out_state", out_state_v[2], 128'h0);
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] single block and latency sweep");
    applyStimulus(128'h637c777bf26b6fc53001672bfed7ab76, 1'b1);
    for (int k = 0; k < 5; k++) lat[k] = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) begin
        if (out_valid_v[k] && lat[k] == 0) begin
          lat[k] = n;
          checkOutput($sformatf("single result bpc=%0d", 1 << k), out_state_v[k],
                      128'h000102030405060708090a0b0c0d0e0f);
        end
      end
    end
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("latency bpc=%0d", 1 << k), 128'(lat[k]), 128'(16 >> k));

    $display("[TB] backpressure with in_valid held");
    in_valid  = 1'b1;
    in_state  = {16{8'h16}};
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_state = {16{8'h63}};
    repeat (38) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("stall result bpc=%0d", 1 << k), out_state_v[k], {16{8'hff}});
      checkOutput($sformatf("stall in_ready bpc=%0d", 1 << k), 128'(in_ready_v[k]), 128'h0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("second block bpc=%0d", 1 << k), out_state_v[k], 128'h0);

    $display("[TB] reset mid-operation");
    applyStimulus(128'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("async rst out_valid bpc=%0d", 1 << k), 128'(out_valid_v[k]), 128'h0);
      checkOutput($sformatf("async rst in_ready bpc=%0d", 1 << k), 128'(in_ready_v[k]), 128'h1);
      checkOutput($sformatf("async rst busy bpc=%0d", 1 << k), 128'(busy_v[k]), 128'h0);
      checkOutput($sformatf("async rst out_state bpc=%0d", 1 << k), out_state_v[k], 128'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus({16{8'hed}}, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++)
      checkOutput($sformatf("post-reset block bpc=%0d", 1 << k), out_state_v[k], {16{8'h53}});

    $display("[TB] exhaustive table on 16 bytes/cycle engine");
    for (int blk = 0; blk < 16; blk++) begin
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = 8'(blk * 16 + i);
      applyStimulus(v, 1'b1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 16; i++)
        checkOutput($sformatf("exhaustive byte %02h", v[127-8*i -: 8]),
                    128'(fwd_tab[out_state_v[4][127-8*i -: 8]]), 128'(v[127-8*i -: 8]));
      @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    #1;

    $display("[TB] randomized traffic");
    for (int n = 0; n < 300; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_state  = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
